// File: rtl/clk_sched_pkg.sv
// Shared constants and types for the clock-enable scheduler.
package clk_sched_pkg;

  localparam int NCH_DEFAULT     = 4;
  localparam int W_DEFAULT       = 19;
  // Channel 0 reproduces the legacy CLK/2^19 square wave out of reset.
  localparam int DEF_DIV_DEFAULT = 2**18 - 1;

  // Config path: one pending slot, either free or holding a request.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/clk_sched_chan.sv
// One scheduler channel: divide counter, one-cycle TICK strobe and 50% PHASE.
// A load replaces div/en and restarts the count; the top only raises load
// while the channel is disabled or on its wrap cycle, so outputs never glitch.
module clk_sched_chan
  import clk_sched_pkg::*;
#(
  parameter int           W       = W_DEFAULT,
  parameter bit           RST_EN  = 1'b0,
  parameter logic [W-1:0] RST_DIV = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] new_div,
  input  logic         new_en,
  output logic         tick,
  output logic         phase,
  output logic         active,
  output logic         wrap
);

  logic [W-1:0] div;
  logic [W-1:0] cnt;

  // Wrap edge of the running period; cnt never exceeds div.
  assign wrap   = active && (cnt == div);

  // Counter, divisor and strobe registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      active <= RST_EN;
      div    <= RST_DIV;
      cnt    <= '0;
      tick   <= 1'b0;
      phase  <= 1'b0;
    end else if (load) begin
      active <= new_en;
      div    <= new_div;
      cnt    <= '0;
      if (!new_en) begin
        // Disabling suppresses the final strobe of the old period.
        tick  <= 1'b0;
        phase <= 1'b0;
      end else if (wrap) begin
        // The old period still completes with its strobe.
        tick  <= 1'b1;
        phase <= ~phase;
      end else begin
        tick  <= 1'b0;
      end
    end else if (active) begin
      if (wrap) begin
        cnt   <= '0;
        tick  <= 1'b1;
        phase <= ~phase;
      end else begin
        cnt   <= cnt + W'(1);
        tick  <= 1'b0;
      end
    end else begin
      cnt   <= '0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// Programmable multi-channel clock-enable scheduler. Holds the config FSM,
// the single pending request slot and the CFG_ERR register; each channel
// applies a pending request at its own period boundary.
module clk_en_sched
  import clk_sched_pkg::*;
#(
  parameter int           NCH     = NCH_DEFAULT,
  parameter int           W       = W_DEFAULT,
  parameter logic [W-1:0] DEF_DIV = W'(DEF_DIV_DEFAULT),
  // Wide enough that an out-of-range channel number is expressible.
  localparam int          CH_W    = $clog2(NCH + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CFG_VALID,
  output logic            CFG_READY,
  input  logic [CH_W-1:0] CFG_CH,
  input  logic [W-1:0]    CFG_DIV,
  input  logic            CFG_EN,
  output logic            CFG_ERR,
  output logic [NCH-1:0]  TICK,
  output logic [NCH-1:0]  PHASE,
  output logic [NCH-1:0]  ACTIVE
);

  cfg_state_e      state;
  logic [CH_W-1:0] pend_ch;
  logic [W-1:0]    pend_div;
  logic            pend_en;
  logic [NCH-1:0]  wrap;
  logic [NCH-1:0]  load;

  assign CFG_READY = (state == IDLE);

  // Apply the pending request when its channel is idle or at its wrap edge.
  // NOTE: load gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    load = '0;
    if (state == PEND) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend_ch == CH_W'(i) && (!ACTIVE[i] || wrap[i])) load[i] = 1'b1;
      end
    end
  end

  // Config FSM: accept into the pending slot, flag bad channels, free on apply.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pend_ch  <= '0;
      pend_div <= '0;
      pend_en  <= 1'b0;
      CFG_ERR  <= 1'b0;
    end else begin
      CFG_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CFG_VALID) begin
            if (CFG_CH >= CH_W'(NCH)) begin
              CFG_ERR <= 1'b1;
            end else begin
              pend_ch  <= CFG_CH;
              pend_div <= CFG_DIV;
              pend_en  <= CFG_EN;
              state    <= PEND;
            end
          end
        end
        PEND: begin
          if (|load) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_sched_chan #(
      .W       (W),
      .RST_EN  (g == 0),
      .RST_DIV ((g == 0) ? DEF_DIV : '0)
    ) u_chan (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .load    (load[g]),
      .new_div (pend_div),
      .new_en  (pend_en),
      .tick    (TICK[g]),
      .phase   (PHASE[g]),
      .active  (ACTIVE[g]),
      .wrap    (wrap[g])
    );
  end

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed self-checking bench for clk_en_sched, run with a scaled-down
// channel 0 default (W=8, DEF_DIV=127: TICK every 128, PHASE period 256).
module tb_clk_en_sched;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int CH_W = 3;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            CFG_VALID;
  logic            CFG_READY;
  logic [CH_W-1:0] CFG_CH;
  logic [W-1:0]    CFG_DIV;
  logic            CFG_EN;
  logic            CFG_ERR;
  logic [NCH-1:0]  TICK;
  logic [NCH-1:0]  PHASE;
  logic [NCH-1:0]  ACTIVE;

  int n_checks = 0;
  int n_fail   = 0;

  clk_en_sched #(
    .NCH     (NCH),
    .W       (W),
    .DEF_DIV (8'd127)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .CFG_CH    (CFG_CH),
    .CFG_DIV   (CFG_DIV),
    .CFG_EN    (CFG_EN),
    .CFG_ERR   (CFG_ERR),
    .TICK      (TICK),
    .PHASE     (PHASE),
    .ACTIVE    (ACTIVE)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cfg(input int ch, input int div, input bit en);
    CFG_VALID = 1'b1;
    CFG_CH    = CH_W'(ch);
    CFG_DIV   = W'(div);
    CFG_EN    = en;
  endtask

  task automatic drop_cfg();
    CFG_VALID = 1'b0;
  endtask

  // Cycles until TICK[ch] is next seen high, bounded by budget.
  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!TICK[ch] && n < budget);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic seen;
    logic exp_ph;

    RST_N = 1'b0;
    drop_cfg();
    CFG_CH = '0;
    CFG_DIV = '0;
    CFG_EN = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_tick",   TICK,      0);
    check("rst_phase",  PHASE,     0);
    check("rst_active", ACTIVE,    4'b0001);
    check("rst_ready",  CFG_READY, 1);
    check("rst_err",    CFG_ERR,   0);

    // Channel 0 default: TICK every 128 cycles, PHASE toggles on each
    RST_N = 1'b1;
    wait_tick(0, 300, n);
    check("ch0_first_tick", n, 128);
    check("ch0_phase_hi", PHASE[0], 1);
    wait_tick(0, 300, n);
    check("ch0_period", n, 128);
    check("ch0_phase_lo", PHASE[0], 0);

    // Enable ch1 D=3 from disabled: apply next edge, ready low 1 cycle
    drive_cfg(1, 3, 1'b1);
    cyc();
    drop_cfg();
    check("ch1_en_ready_lo", CFG_READY, 0);
    cyc();
    check("ch1_en_ready_hi", CFG_READY, 1);
    check("ch1_en_active", ACTIVE[1], 1);
    wait_tick(1, 20, n);
    check("ch1_first_tick", n, 4);
    wait_tick(1, 20, n);
    check("ch1_period", n, 4);

    // ch2 D=9, then change to D=2 accepted on the edge making cnt=4
    drive_cfg(2, 9, 1'b1);
    cyc();
    drop_cfg();
    cyc();
    check("ch2_en_active", ACTIVE[2], 1);
    cyc();
    cyc();
    cyc();
    drive_cfg(2, 2, 1'b1);
    cyc();
    drop_cfg();
    check("ch2_chg_ready_lo", CFG_READY, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seen = seen | CFG_READY | TICK[2];
    end
    check("ch2_chg_wait_quiet", seen, 0);
    cyc();
    check("ch2_old_tick", TICK[2], 1);
    check("ch2_chg_ready_hi", CFG_READY, 1);
    wait_tick(2, 20, n);
    check("ch2_new_period_a", n, 3);
    wait_tick(2, 20, n);
    check("ch2_new_period_b", n, 3);

    // Disable ch1 accepted on the edge making cnt=1: last strobe suppressed
    wait_tick(1, 20, n);
    drive_cfg(1, 3, 1'b0);
    cyc();
    drop_cfg();
    cyc();
    cyc();
    check("ch1_dis_pre_tick", TICK[1], 0);
    check("ch1_dis_pre_active", ACTIVE[1], 1);
    cyc();
    check("ch1_dis_tick", TICK[1], 0);
    check("ch1_dis_phase", PHASE[1], 0);
    check("ch1_dis_active", ACTIVE[1], 0);
    check("ch1_dis_ready", CFG_READY, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      seen = seen | TICK[1] | PHASE[1];
    end
    check("ch1_dis_quiet", seen, 0);

    // Out-of-range channel: one-cycle CFG_ERR, nothing else changes
    drive_cfg(5, 7, 1'b1);
    cyc();
    drop_cfg();
    check("err_pulse", CFG_ERR, 1);
    check("err_ready", CFG_READY, 1);
    cyc();
    check("err_clear", CFG_ERR, 0);
    check("err_active", ACTIVE, 4'b0101);

    // Max divisor on ch2: applied at its wrap, then 256-cycle period
    drive_cfg(2, 255, 1'b1);
    cyc();
    drop_cfg();
    n = 0;
    while (!CFG_READY && n < 10) begin
      cyc();
      n++;
    end
    check("ch2_max_apply_tick", TICK[2], 1);
    wait_tick(2, 300, n);
    check("ch2_max_period", n, 256);

    // ch3 D=0: TICK continuously high, PHASE = CLK/2
    wait_tick(0, 300, n);
    drive_cfg(3, 0, 1'b1);
    cyc();
    drop_cfg();
    cyc();
    check("ch3_apply_tick", TICK[3], 0);
    bad = 0;
    exp_ph = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (TICK[3] !== 1'b1 || PHASE[3] !== exp_ph) bad++;
      exp_ph = ~exp_ph;
    end
    check("ch3_d0_pattern", bad, 0);

    // Reset while a ch0 request is pending
    drive_cfg(0, 5, 1'b1);
    cyc();
    drop_cfg();
    check("ch0_pend_ready_lo", CFG_READY, 0);
    cyc();
    cyc();
    #3;
    RST_N = 1'b0;
    #1;
    check("mid_rst_tick",   TICK,      0);
    check("mid_rst_phase",  PHASE,     0);
    check("mid_rst_active", ACTIVE,    4'b0001);
    check("mid_rst_ready",  CFG_READY, 1);
    check("mid_rst_err",    CFG_ERR,   0);
    cyc();
    cyc();
    RST_N = 1'b1;
    wait_tick(0, 300, n);
    check("post_rst_ch0_period", n, 128);
    check("post_rst_active", ACTIVE, 4'b0001);
    check("post_rst_ch3_tick", TICK[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
